debug_stepper: RTL and testbench

//  Generates debug_en/debug_step for the 5-stage pipeline controller: halts the pipeline,

---
 rtl/debug_stepper.sv | 207 ++++++++++++++++++++
 tb/tb_debug_stepper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_stepper.sv
// Purpose : pipeline debug stepper - halts the 5-stage pipeline, issues single or burst step pulses, halts on an IF-PC breakpoint.
// Latency : debug_en/debug_step are registered (1 cycle after the FSM decision); the switch/button path adds DEBOUNCE_CYCLES+2 cycles.
// Backpres: none - step/burst requests arriving outside HALT are dropped, not queued.
//
// Ports:
//   clk, rst        main clock, asynchronous active-low reset
//   sw_debug        raw debug-mode switch (asynchronous)
//   btn_step        raw step push-button (asynchronous, bouncy)
//   run_burst       1-cycle strobe: issue step_len pulses (0 treated as 1)
//   step_len        burst length
//   bp_en, bp_addr  breakpoint enable and PC
//   pc_if           current IF-stage PC
//   debug_en        pipeline suspended while high
//   debug_step      step pulse, one cycle wide, at least one low cycle between pulses
//   bp_hit          sticky breakpoint-halt flag
//   busy            burst/step in progress
//   steps_done      pulses issued since reset, wrapping

module debug_stepper #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_debug,
  input  logic              btn_step,
  input  logic              run_burst,
  input  logic [STEP_W-1:0] step_len,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc_if,
  output logic              debug_en,
  output logic              debug_step,
  output logic              bp_hit,
  output logic              busy,
  output logic [STEP_W-1:0] steps_done
);

  // Debounce counter only ever needs to hold 0..DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 = debug switch, index 1 = step button.
  localparam int SW  = 0;
  localparam int BTN = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HALT  = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // ------------------------------------------------------------------
  // Input conditioning: 2-FF synchronizer followed by a debounce filter
  // ------------------------------------------------------------------
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            filt_q;
  logic [1:0]            filt_d;
  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_d;
  logic                  btn_prev_q;
  logic                  step_req;
  logic                  sw_filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      cnt_q      <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {btn_step, sw_debug};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= filt_q[BTN];
    end
  end

  // The counter only runs while the synced level disagrees with the
  // filtered level; any bounce back to the filtered level restarts it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i]  = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sw_filt  = filt_q[SW];
  assign step_req = filt_q[BTN] & ~btn_prev_q;

  // ------------------------------------------------------------------
  // Stepper FSM
  // ------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [STEP_W-1:0] rem_q;
  logic [STEP_W-1:0] rem_d;
  logic              bp_hit_q;
  logic              bp_hit_d;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] steps_d;
  logic              debug_en_q;
  logic              debug_step_q;
  logic              bp_match;

  assign bp_match = bp_en && (pc_if == bp_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      bp_hit_q     <= 1'b0;
      steps_q      <= '0;
      debug_en_q   <= 1'b0;
      debug_step_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      bp_hit_q     <= bp_hit_d;
      steps_q      <= steps_d;
      // Outputs are registered from the next state so they line up
      // exactly with the state they describe.
      debug_en_q   <= (state_d != S_IDLE);
      debug_step_q <= (state_d == S_PULSE);
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    bp_hit_d = bp_hit_q;
    steps_d  = steps_q;

    unique case (state_q)
      S_IDLE: begin
        // Breakpoint has priority so bp_hit is recorded even when the
        // switch is also on.
        if (bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else if (sw_filt) begin
          state_d  = S_HALT;
        end
      end

      S_HALT: begin
        if (step_req) begin
          rem_d    = STEP_W'(1);
          bp_hit_d = 1'b0;
          state_d  = S_PULSE;
        end else if (run_burst) begin
          rem_d    = (step_len == '0) ? STEP_W'(1) : step_len;
          bp_hit_d = 1'b0;
          state_d  = S_PULSE;
        end else if (!sw_filt && !bp_hit_q) begin
          state_d  = S_IDLE;
        end
      end

      S_PULSE: begin
        steps_d = steps_q + 1'b1;
        if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end
        state_d = S_GAP;
      end

      S_GAP: begin
        // The low cycle guarantees the controller sees a fresh rising
        // edge on the next pulse; the breakpoint is only checked here,
        // between pulses, while the pipeline is settled.
        if (rem_q != '0) begin
          if (bp_match) begin
            state_d  = S_HALT;
            bp_hit_d = 1'b1;
            rem_d    = '0;
          end else begin
            state_d  = S_PULSE;
          end
        end else begin
          state_d = S_HALT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign debug_en   = debug_en_q;
  assign debug_step = debug_step_q;
  assign bp_hit     = bp_hit_q;
  assign busy       = (state_q == S_PULSE) || (state_q == S_GAP);
  assign steps_done = steps_q;

endmodule

// File: tb/tb_debug_stepper.sv
// Directed bench for debug_stepper with DEBOUNCE_CYCLES=4.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_debug_stepper;

  localparam int STEP_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              sw_debug;
  logic              btn_step;
  logic              run_burst;
  logic [STEP_W-1:0] step_len;
  logic              bp_en;
  logic [31:0]       bp_addr;
  logic [31:0]       pc_if;
  logic              debug_en;
  logic              debug_step;
  logic              bp_hit;
  logic              busy;
  logic [STEP_W-1:0] steps_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_steps = 0;

  always #5 clk = ~clk;

  debug_stepper #(.DEBOUNCE_CYCLES(4), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_debug   (sw_debug),
    .btn_step   (btn_step),
    .run_burst  (run_burst),
    .step_len   (step_len),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_if      (pc_if),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .bp_hit     (bp_hit),
    .busy       (busy),
    .steps_done (steps_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values, then debug_en rising 7 cycles after release with sw held.
  task automatic test_reset();
    int rise = 0;
    int pulses = 0;
    repeat (3) tick();
    n_checks++; if (debug_en !== 1'b0) begin n_fail++; $display("FAIL rst_debug_en: got %b want 0", debug_en); end
    n_checks++; if (debug_step !== 1'b0) begin n_fail++; $display("FAIL rst_debug_step: got %b want 0", debug_step); end
    n_checks++; if (bp_hit !== 1'b0) begin n_fail++; $display("FAIL rst_bp_hit: got %b want 0", bp_hit); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (steps_done !== 16'd0) begin n_fail++; $display("FAIL rst_steps: got %0d want 0", steps_done); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (debug_en === 1'b1 && rise == 0) rise = i;
      if (debug_step !== 1'b0) pulses++;
    end
    n_checks++; if (rise != 7) begin n_fail++; $display("FAIL entry_latency: got %0d want 7", rise); end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL entry_no_step: got %0d want 0", pulses); end
  endtask

  // Bouncy button: 1,0,1 then held 1 for 10 cycles, then released.
  task automatic test_step_bounce();
    int pulses = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 23; i++) begin
      btn_step = (i == 1) ? 1'b0 : (i < 13);
      tick();
      if (debug_step === 1'b1 && prev === 1'b0) pulses++;
      prev = debug_step;
    end
    btn_step = 1'b0;
    exp_steps += 1;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
    n_checks++; if (steps_done !== 16'(exp_steps)) begin n_fail++; $display("FAIL bounce_steps: got %0d want %0d", steps_done, exp_steps); end
    n_checks++; if (debug_en !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bounce_halt: got en=%b busy=%b want en=1 busy=0", debug_en, busy); end
  endtask

  // Burst from HALT: expect n pulses on even cycles, busy for 2n cycles.
  task automatic test_burst(input logic [STEP_W-1:0] len, input int n);
    int bad_step = 0;
    int bad_busy = 0;
    int bad_en = 0;
    logic exp_s;
    step_len  = len;
    run_burst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      run_burst = 1'b0;
      exp_s = (i < 2 * n) && (i % 2 == 0);
      if (debug_step !== exp_s) bad_step++;
      if (busy !== (i < 2 * n)) bad_busy++;
      if (debug_en !== 1'b1) bad_en++;
    end
    exp_steps += n;
    n_checks++; if (bad_step != 0) begin n_fail++; $display("FAIL burst%0d_step_pattern: got %0d bad cycles want 0", len, bad_step); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL burst%0d_busy_pattern: got %0d bad cycles want 0", len, bad_busy); end
    n_checks++; if (bad_en != 0) begin n_fail++; $display("FAIL burst%0d_debug_en: got %0d low cycles want 0", len, bad_en); end
    n_checks++; if (steps_done !== 16'(exp_steps)) begin n_fail++; $display("FAIL burst%0d_steps: got %0d want %0d", len, steps_done, exp_steps); end
  endtask

  task automatic test_exit_idle();
    sw_debug = 1'b0;
    repeat (12) tick();
    n_checks++; if (debug_en !== 1'b0) begin n_fail++; $display("FAIL exit_idle_en: got %b want 0", debug_en); end
  endtask

  // Breakpoint from free run, then resume with one step press.
  task automatic test_breakpoint_idle();
    int pulses = 0;
    int bad_bp = 0;
    bp_en = 1'b1; bp_addr = 32'h20; pc_if = 32'h10;
    repeat (2) tick();
    n_checks++; if (debug_en !== 1'b0) begin n_fail++; $display("FAIL bp_nomatch_en: got %b want 0", debug_en); end
    pc_if = 32'h20;
    tick();
    n_checks++; if (debug_en !== 1'b1) begin n_fail++; $display("FAIL bp_hit_en: got %b want 1", debug_en); end
    n_checks++; if (bp_hit !== 1'b1) begin n_fail++; $display("FAIL bp_hit_flag: got %b want 1", bp_hit); end
    pc_if = 32'h24;
    repeat (3) tick();
    n_checks++; if (debug_en !== 1'b1) begin n_fail++; $display("FAIL bp_sticky_halt: got %b want 1", debug_en); end
    for (int i = 0; i < 20; i++) begin
      btn_step = (i < 10);
      tick();
      if (debug_step === 1'b1) begin
        pulses++;
        if (bp_hit !== 1'b0) bad_bp++;
      end
    end
    btn_step = 1'b0;
    exp_steps += 1;
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bp_resume_pulses: got %0d want 1", pulses); end
    n_checks++; if (bad_bp != 0) begin n_fail++; $display("FAIL bp_clear_on_step: got %0d want 0", bad_bp); end
    n_checks++; if (debug_en !== 1'b0 || bp_hit !== 1'b0) begin n_fail++; $display("FAIL bp_resume_idle: got en=%b bp=%b want 0 0", debug_en, bp_hit); end
    n_checks++; if (steps_done !== 16'(exp_steps)) begin n_fail++; $display("FAIL bp_resume_steps: got %0d want %0d", steps_done, exp_steps); end
  endtask

  // Burst of 8 abandoned by a breakpoint seen during the 3rd gap.
  task automatic test_burst_breakpoint();
    int pulses = 0;
    sw_debug = 1'b1; pc_if = 32'h30;
    repeat (10) tick();
    n_checks++; if (debug_en !== 1'b1 || bp_hit !== 1'b0) begin n_fail++; $display("FAIL bpb_setup: got en=%b bp=%b want 1 0", debug_en, bp_hit); end
    step_len  = 16'd8;
    run_burst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      run_burst = 1'b0;
      if (debug_step === 1'b1) pulses++;
      if (i == 5) begin
        n_checks++; if (busy !== 1'b1 || debug_step !== 1'b0) begin n_fail++; $display("FAIL bpb_gap3: got busy=%b step=%b want 1 0", busy, debug_step); end
        pc_if = 32'h20;
      end
    end
    pc_if = 32'h30;
    exp_steps += 3;
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL bpb_pulses: got %0d want 3", pulses); end
    n_checks++; if (bp_hit !== 1'b1 || busy !== 1'b0 || debug_en !== 1'b1) begin n_fail++; $display("FAIL bpb_halt: got bp=%b busy=%b en=%b want 1 0 1", bp_hit, busy, debug_en); end
    n_checks++; if (steps_done !== 16'(exp_steps)) begin n_fail++; $display("FAIL bpb_steps: got %0d want %0d", steps_done, exp_steps); end
  endtask

  // Asynchronous reset in the middle of a pulse.
  task automatic test_reset_mid_burst();
    int pulses = 0;
    step_len  = 16'd8;
    run_burst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      run_burst = 1'b0;
    end
    n_checks++; if (debug_step !== 1'b1) begin n_fail++; $display("FAIL mid_pre_pulse: got %b want 1", debug_step); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (debug_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_en: got %b want 0", debug_en); end
    n_checks++; if (debug_step !== 1'b0) begin n_fail++; $display("FAIL async_rst_step: got %b want 0", debug_step); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b want 0", busy); end
    n_checks++; if (steps_done !== 16'd0) begin n_fail++; $display("FAIL async_rst_steps: got %0d want 0", steps_done); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (debug_step !== 1'b0 || debug_en !== 1'b0) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_hold_quiet: got %0d active cycles want 0", pulses); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; sw_debug = 1'b1; btn_step = 1'b0; run_burst = 1'b0;
    step_len = '0; bp_en = 1'b0; bp_addr = '0; pc_if = '0;
    test_reset();
    test_step_bounce();
    test_burst(16'd5, 5);
    test_burst(16'd0, 1);
    test_exit_idle();
    test_breakpoint_idle();
    test_burst_breakpoint();
    test_reset_mid_burst();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
